// File: rtl/tpu_pkg.sv
// Shared definitions for the TPU instruction sequencer.
//   opcode_t    : 3-bit instruction opcode (bits 15:13 of an instruction word)
//   seq_state_t : sequencer FSM state encoding
//   decoded_t   : result of decode(): opcode, 13-bit operand, illegal flag
package tpu_pkg;

    localparam int OPC_W   = 3;
    localparam int INSTR_W = 16;
    localparam int ADDR_W  = 13;

    typedef enum logic [OPC_W-1:0] {
        OP_END         = 3'b000,
        OP_LOAD_ADDR   = 3'b001,
        OP_LOAD_WEIGHT = 3'b010,
        OP_LOAD_INPUT  = 3'b011,
        OP_COMPUTE     = 3'b100,
        OP_STORE       = 3'b101
    } opcode_t;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_EXEC    = 3'd2,
        S_COMPUTE = 3'd3,
        S_HALT    = 3'd4
    } seq_state_t;

    typedef struct packed {
        opcode_t             opcode;
        logic [ADDR_W-1:0]   operand;
        logic                illegal;
    } decoded_t;

    // Codes 110 and 111 have no enum member; they are flagged as illegal so
    // the FSM never looks at the opcode field for them.
    function automatic decoded_t decode(input logic [INSTR_W-1:0] instr);
        decoded_t d;
        d.opcode  = opcode_t'(instr[INSTR_W-1 -: OPC_W]);
        d.operand = instr[ADDR_W-1:0];
        d.illegal = (instr[INSTR_W-1 -: 2] == 2'b11);
        return d;
    endfunction

endpackage

// File: rtl/tpu_sequencer.sv
// Instruction sequencer for the TPU datapath.
// Fetches 16-bit instructions from an external synchronous instruction memory
// (one outstanding read, no prefetch) and drives the datapath control strobes.
//
// Ports:
//   clk, reset    : clock, synchronous active-high reset
//   start         : request to run the program from address 0
//   imem_addr     : instruction read address (equals the program counter)
//   imem_rdata    : instruction word, valid the cycle after imem_addr
//   base_address  : operand captured by LOAD_ADDR
//   load_weight, load_input, store : one-cycle strobes
//   valid         : compute enable, high COMPUTE_CYCLES consecutive cycles
//   busy, done, error : run status
//   state_dbg     : current FSM state, for observation only
//
// Handshake: start is sampled only in IDLE or HALT (busy=0); while busy=1 it
// is ignored. busy rises the cycle after an accepted start and falls in the
// same cycle that done rises. done/error then hold until the next accepted
// start (which clears them) or reset.
module tpu_sequencer
    import tpu_pkg::*;
#(
    parameter int IMEM_DEPTH     = 8,
    parameter int ADDR_W         = 13,
    parameter int COMPUTE_CYCLES = 6,
    localparam int PC_W          = $clog2(IMEM_DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [15:0]       imem_rdata,
    output logic [ADDR_W-1:0] base_address,
    output logic              load_weight,
    output logic              load_input,
    output logic              valid,
    output logic              store,
    output logic              busy,
    output logic              done,
    output logic              error,
    output seq_state_t        state_dbg
);

    localparam logic [PC_W-1:0] LAST_PC  = PC_W'(IMEM_DEPTH - 1);
    localparam logic [7:0]      CNT_LAST = 8'(COMPUTE_CYCLES - 1);

    seq_state_t      state;
    logic [PC_W-1:0] pc;
    logic [7:0]      cnt;
    decoded_t        dec;

    // pc is a register, so the memory address is registered as well.
    assign imem_addr = pc;
    assign state_dbg = state;
    assign dec       = decode(imem_rdata);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            pc           <= '0;
            cnt          <= '0;
            base_address <= '0;
            load_weight  <= 1'b0;
            load_input   <= 1'b0;
            valid        <= 1'b0;
            store        <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
        end else begin
            // One-cycle strobes default low; valid is held explicitly.
            load_weight <= 1'b0;
            load_input  <= 1'b0;
            store       <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        pc    <= '0;
                        busy  <= 1'b1;
                        state <= S_FETCH;
                    end
                end

                S_FETCH: begin
                    state <= S_EXEC;
                end

                S_EXEC: begin
                    if (dec.illegal) begin
                        done  <= 1'b1;
                        error <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_HALT;
                    end else if (dec.opcode == OP_END) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_HALT;
                    end else if (dec.opcode == OP_COMPUTE) begin
                        valid <= 1'b1;
                        cnt   <= '0;
                        state <= S_COMPUTE;
                    end else begin
                        case (dec.opcode)
                            OP_LOAD_ADDR:   base_address <= ADDR_W'(dec.operand);
                            OP_LOAD_WEIGHT: load_weight  <= 1'b1;
                            OP_LOAD_INPUT:  load_input   <= 1'b1;
                            OP_STORE:       store        <= 1'b1;
                            default:        ;
                        endcase
                        // The last word executes normally; running off the end
                        // halts with error instead of wrapping pc.
                        if (pc == LAST_PC) begin
                            done  <= 1'b1;
                            error <= 1'b1;
                            busy  <= 1'b0;
                            state <= S_HALT;
                        end else begin
                            pc    <= pc + 1'b1;
                            state <= S_FETCH;
                        end
                    end
                end

                S_COMPUTE: begin
                    if (cnt == CNT_LAST) begin
                        valid <= 1'b0;
                        if (pc == LAST_PC) begin
                            done  <= 1'b1;
                            error <= 1'b1;
                            busy  <= 1'b0;
                            state <= S_HALT;
                        end else begin
                            pc    <= pc + 1'b1;
                            state <= S_FETCH;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end

                S_HALT: begin
                    if (start) begin
                        done  <= 1'b0;
                        error <= 1'b0;
                        pc    <= '0;
                        busy  <= 1'b1;
                        state <= S_FETCH;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tpu_sequencer.sv
module tb_tpu_sequencer;
    import tpu_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start, start1;
    logic [2:0]  imem_addr, imem_addr1;
    logic [15:0] imem_rdata, imem_rdata1;
    logic [12:0] base_address, base_address1;
    logic        load_weight, load_input, valid, store, busy, done, error;
    logic        load_weight1, load_input1, valid1, store1, busy1, done1, error1;
    seq_state_t  state_dbg, state_dbg1;

    logic [15:0] mem  [8];
    logic [15:0] mem1 [8];

    // Synchronous instruction memories.
    always @(posedge clk) begin
        imem_rdata  <= mem[imem_addr];
        imem_rdata1 <= mem1[imem_addr1];
    end

    tpu_sequencer #(.IMEM_DEPTH(8), .ADDR_W(13), .COMPUTE_CYCLES(6)) dut (
        .clk(clk), .reset(reset), .start(start),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .base_address(base_address), .load_weight(load_weight),
        .load_input(load_input), .valid(valid), .store(store),
        .busy(busy), .done(done), .error(error), .state_dbg(state_dbg)
    );

    tpu_sequencer #(.IMEM_DEPTH(8), .ADDR_W(13), .COMPUTE_CYCLES(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1),
        .imem_addr(imem_addr1), .imem_rdata(imem_rdata1),
        .base_address(base_address1), .load_weight(load_weight1),
        .load_input(load_input1), .valid(valid1), .store(store1),
        .busy(busy1), .done(done1), .error(error1), .state_dbg(state_dbg1)
    );

    // ---------------- scoreboard ----------------
    localparam int K_LW = 1, K_LI = 2, K_ST = 3, K_VAL = 4, K_DONE = 5;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];

    function automatic logic [15:0] ev(input int k, input int d);
        return {k[2:0], d[12:0]};
    endfunction

    function automatic logic [15:0] ins(input logic [2:0] op, input int opd);
        return {op, opd[12:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic observe(input logic [15:0] g);
        logic [15:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got 0x%0h expected none at %0t", g, $time);
        end else begin
            e = exp_q.pop_front();
            check("event", {16'd0, g}, {16'd0, e});
        end
    endtask

    // Monitor: turns DUT outputs into events and matches them in order.
    int   vw = 0;
    logic prev_done = 1'b0;
    always @(negedge clk) begin
        if (load_weight | load_input | store | valid)
            check("strobe_onehot", 32'($countones({load_weight, load_input, store, valid}) <= 1), 32'd1);
        if (load_weight) observe(ev(K_LW, int'(base_address)));
        if (load_input)  observe(ev(K_LI, int'(base_address)));
        if (store)       observe(ev(K_ST, int'(base_address)));
        if (valid) vw++;
        else if (vw > 0) begin
            observe(ev(K_VAL, vw));
            vw = 0;
        end
        if (done && !prev_done) observe(ev(K_DONE, int'(error)));
        prev_done = done;
    end

    // ---------------- driver tasks ----------------
    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(name, {31'd0, done}, 32'd1);
    endtask

    task automatic wait_valid(input logic lvl);
        int n = 0;
        while (valid !== lvl && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("wait_valid", {31'd0, valid}, {31'd0, lvl});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int w1;
        logic wrap;
        logic [2:0] prev_a;

        reset = 1'b1; start = 1'b0; start1 = 1'b0;
        for (int i = 0; i < 8; i++) begin mem[i] = '0; mem1[i] = '0; end
        repeat (3) @(negedge clk);
        check("reset_outputs", {13'd0, base_address, imem_addr, load_weight, load_input,
                                valid, store, busy, done, error}, 32'd0);
        check("reset_state", 32'(state_dbg), 32'(S_IDLE));
        reset = 1'b0;
        @(negedge clk);

        // COMPUTE_CYCLES=1: valid is exactly one cycle wide.
        mem1 = '{ins(4, 0), ins(0, 0), 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
        @(negedge clk); start1 = 1'b1;
        @(negedge clk); start1 = 1'b0;
        w1 = 0; n = 0;
        while (!done1 && n < 100) begin
            if (valid1) w1++;
            @(negedge clk);
            n++;
        end
        check("cc1_valid_width", 32'(w1), 32'd1);
        check("cc1_done_error", {30'd0, done1, error1}, 32'b10);

        // Full program.
        mem = '{ins(1, 'h0F), ins(2, 0), ins(1, 'h1E), ins(3, 0),
                ins(4, 0), ins(1, 'h07), ins(5, 0), ins(0, 0)};
        exp_q.push_back(ev(K_LW, 'h0F));
        exp_q.push_back(ev(K_LI, 'h1E));
        exp_q.push_back(ev(K_VAL, 6));
        exp_q.push_back(ev(K_ST, 'h07));
        exp_q.push_back(ev(K_DONE, 0));
        pulse_start();
        check("t1_busy_after_start", {31'd0, busy}, 32'd1);
        repeat (25) @(negedge clk);
        check("t1_status_T25", {29'd0, done, error, busy}, 32'b100);

        // {COMPUTE, END} with COMPUTE_CYCLES=6; END fetched right after valid.
        mem = '{ins(4, 0), ins(0, 0), 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
        exp_q.push_back(ev(K_VAL, 6));
        exp_q.push_back(ev(K_DONE, 0));
        pulse_start();
        wait_valid(1'b1);
        wait_valid(1'b0);
        check("t2_fetch_end_addr", 32'(imem_addr), 32'd1);
        check("t2_fetch_end_state", 32'(state_dbg), 32'(S_FETCH));
        wait_done("t2_done");

        // Illegal opcode at address 2, then restart.
        mem = '{ins(1, 5), ins(2, 0), ins(6, 0), ins(3, 0),
                ins(5, 0), ins(0, 0), 16'd0, 16'd0};
        exp_q.push_back(ev(K_LW, 5));
        exp_q.push_back(ev(K_DONE, 1));
        pulse_start();
        wait_done("t3_done");
        check("t3_error", {31'd0, error}, 32'd1);
        check("t3_halt_addr", 32'(imem_addr), 32'd2);
        exp_q.push_back(ev(K_LW, 5));
        exp_q.push_back(ev(K_DONE, 1));
        pulse_start();
        check("t3_restart_clears", {30'd0, done, error}, 32'd0);
        check("t3_restart_addr", 32'(imem_addr), 32'd0);
        wait_done("t3_done2");

        // Overrun: eight words, no END.
        mem = '{ins(1, 1), ins(2, 0), ins(3, 0), ins(5, 0),
                ins(1, 2), ins(2, 0), ins(3, 0), ins(5, 0)};
        exp_q.push_back(ev(K_LW, 1));
        exp_q.push_back(ev(K_LI, 1));
        exp_q.push_back(ev(K_ST, 1));
        exp_q.push_back(ev(K_LW, 2));
        exp_q.push_back(ev(K_LI, 2));
        exp_q.push_back(ev(K_ST, 2));
        exp_q.push_back(ev(K_DONE, 1));
        pulse_start();
        wrap = 1'b0; prev_a = imem_addr; n = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            if (imem_addr < prev_a) wrap = 1'b1;
            prev_a = imem_addr;
            n++;
        end
        check("t4_done", {31'd0, done}, 32'd1);
        check("t4_error", {31'd0, error}, 32'd1);
        check("t4_no_wrap", {31'd0, wrap}, 32'd0);
        check("t4_final_addr", 32'(imem_addr), 32'd7);

        // Reset on the third valid cycle.
        mem = '{ins(1, 'h0F), ins(2, 0), ins(1, 'h1E), ins(3, 0),
                ins(4, 0), ins(1, 'h07), ins(5, 0), ins(0, 0)};
        exp_q.push_back(ev(K_LW, 'h0F));
        exp_q.push_back(ev(K_LI, 'h1E));
        exp_q.push_back(ev(K_VAL, 3));
        pulse_start();
        wait_valid(1'b1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("t5_after_reset", {28'd0, valid, busy, done, error}, 32'd0);
        check("t5_base", 32'(base_address), 32'd0);
        check("t5_state", 32'(state_dbg), 32'(S_IDLE));
        reset = 1'b0;
        repeat (10) @(negedge clk);
        check("t5_stays_idle", 32'(state_dbg), 32'(S_IDLE));

        // Mid-run start is ignored; start+reset together leaves IDLE.
        mem = '{ins(1, 9), ins(2, 0), ins(4, 0), ins(5, 0),
                ins(0, 0), 16'd0, 16'd0, 16'd0};
        exp_q.push_back(ev(K_LW, 9));
        exp_q.push_back(ev(K_VAL, 6));
        exp_q.push_back(ev(K_ST, 9));
        exp_q.push_back(ev(K_DONE, 0));
        pulse_start();
        wait_valid(1'b1);
        pulse_start();
        check("t6_still_busy", {31'd0, busy}, 32'd1);
        wait_done("t6_done");
        check("t6_error", {31'd0, error}, 32'd0);
        check("t6_end_addr", 32'(imem_addr), 32'd4);
        @(negedge clk); start = 1'b1; reset = 1'b1;
        @(negedge clk); start = 1'b0; reset = 1'b0;
        check("t6_reset_wins_state", 32'(state_dbg), 32'(S_IDLE));
        check("t6_reset_wins_status", {29'd0, busy, done, error}, 32'd0);
        repeat (5) @(negedge clk);
        check("t6_idle_hold", {31'd0, busy}, 32'd0);

        repeat (5) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tpu_sequencer.md
Name: tpu_sequencer

Overview:
Instruction sequencer for the TPU datapath. It fetches 16-bit instructions from a synchronous instruction memory and decodes them as a 3-bit opcode plus a 13-bit operand. From each instruction it drives the control strobes consumed by weight_memory, input_setup, mmu, the accumulators and unified_buffer. It replaces the ad-hoc fetch/execute FSM at top level and adds start/busy/done/error handshaking.

Parameters:
IMEM_DEPTH, 8, number of instruction words; PC_W = $clog2(IMEM_DEPTH)
ADDR_W, 13, operand/base_address width
COMPUTE_CYCLES, 6, cycles valid is held per COMPUTE instruction (legal range 1 to 255)

Ports:
clk  in  1  clock (single clock domain)
reset  in  1  synchronous, active-high reset
start  in  1  single-cycle request to run the program from address 0
imem_addr  out  PC_W  instruction memory read address
imem_rdata  in  16  instruction word; valid the cycle after imem_addr is presented
base_address  out  ADDR_W  operand latched by LOAD_ADDR
load_weight  out  1  one-cycle strobe
load_input  out  1  one-cycle strobe
valid  out  1  compute enable, held COMPUTE_CYCLES cycles
store  out  1  one-cycle strobe
busy  out  1  program running
done  out  1  program halted (END, error or overrun)
error  out  1  illegal opcode or program overrun

Behaviour:
- Reset (synchronous):
  - state=IDLE, pc=0, cnt=0.
  - All outputs 0, including imem_addr and base_address.
  - Reset mid-program aborts immediately, with no further strobes.
- Opcodes (bits 15:13): 000 END, 001 LOAD_ADDR, 010 LOAD_WEIGHT, 011 LOAD_INPUT, 100 COMPUTE, 101 STORE, 110/111 illegal. Operand = bits 12:0.
- All outputs are registered.
- States: IDLE, FETCH, EXEC, COMPUTE, HALT.
- IDLE: if start, set pc=0 and go to FETCH.
- FETCH (1 cycle): imem_addr=pc; go to EXEC.
- EXEC (1 cycle): decode imem_rdata. The resulting strobe is asserted the next cycle for exactly one cycle.
  - LOAD_ADDR: base_address <= operand (held until the next LOAD_ADDR or reset); no strobe.
  - LOAD_WEIGHT / LOAD_INPUT / STORE: assert the matching strobe.
  - COMPUTE: valid <= 1, cnt <= 0, go to COMPUTE.
  - END: go to HALT, done <= 1, error unchanged.
  - Illegal opcode: go to HALT, done <= 1, error <= 1, no strobe.
  - Any other non-END, non-COMPUTE opcode: pc <= pc+1, go to FETCH.
  - Overrun: if pc == IMEM_DEPTH-1 and the opcode is not END, execute it normally, then go to HALT with done=1 and error=1 (for COMPUTE, after the compute phase completes). pc never wraps.
- COMPUTE:
  - If cnt == COMPUTE_CYCLES-1: valid <= 0, pc <= pc+1, go to FETCH (or HALT on overrun).
  - Otherwise cnt <= cnt+1.
  - Net effect: valid is high for exactly COMPUTE_CYCLES consecutive cycles starting the cycle after EXEC.
- Instruction cost: non-compute instructions take 2 cycles; COMPUTE takes 2+COMPUTE_CYCLES cycles.
- busy=1 in FETCH, EXEC and COMPUTE (registered, tracks state); 0 in IDLE and HALT.
- HALT: done and error held. On start: clear done and error, set pc=0, go to FETCH.
- start is ignored while busy=1.
- Strobes are mutually exclusive: at most one of load_weight, load_input, store, valid is high in any cycle. base_address is stable whenever any strobe is high.
- At most one instruction is outstanding; no prefetch.

Decomposition:
- Shared package tpu_pkg holds:
  - opcode_t enum (3-bit)
  - seq_state_t enum
  - OPC_W=3, INSTR_W=16, ADDR_W=13
  - decode function returning {opcode, operand, illegal}
- No sub-module; the FSM, pc and cnt live in tpu_sequencer. The instruction memory stays external.

Test Plan:
1. Program {LOAD_ADDR 0x000F, LOAD_WEIGHT, LOAD_ADDR 0x001E, LOAD_INPUT, COMPUTE, LOAD_ADDR 0x0007, STORE, END}, start at T -> base_address=0x000F before load_weight; load_weight one cycle; load_input with base_address=0x001E; valid high exactly 6 consecutive cycles; store with base_address=0x0007; done=1, error=0, busy=0 at T+25.
2. COMPUTE_CYCLES=1 and COMPUTE_CYCLES=6, program {COMPUTE, END} -> valid width 1 and 6 respectively; FETCH of END occurs the cycle after valid falls.
3. Illegal opcode 110 at address 2 -> no strobe for that word; done=1, error=1; a following start clears both and reruns from address 0.
4. Eight words, none END -> all eight execute, then done=1, error=1, imem_addr never wraps to 0 before halt.
5. reset asserted on the 3rd valid cycle -> next cycle valid=0, busy=0, base_address=0, state IDLE; no strobe until a new start.
6. start pulsed during a run, and start+reset asserted together -> the run is unaffected by the mid-run start; with start+reset together, reset wins and the block stays IDLE.
